// File: rtl/fetch_queue.sv
// Instruction fetch queue between the align buffer and decode: fetches, length-decodes and buffers instructions.
// Define FETCH_QUEUE_BYPASS_EN to let a response reach inst_* in the same cycle when the queue is empty.
module fetch_queue #(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     DEPTH        = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   redirect_i,
   input  logic [XLEN-1:0]        redirect_pc_i,
   output logic                   fetch_valid_o,
   output logic [XLEN-1:0]        fetch_addr_o,
   input  logic                   fetch_rsp_valid_i,
   input  logic [31:0]            fetch_rsp_data_i,
   output logic                   inst_valid_o,
   input  logic                   inst_ready_i,
   output logic [31:0]            inst_o,
   output logic [XLEN-1:0]        inst_pc_o,
   output logic                   inst_comp_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [XLEN-1:0] pc_mem_d   [DEPTH];
   logic [31:0]     inst_mem_q [DEPTH];
   logic [31:0]     inst_mem_d [DEPTH];
   logic [DEPTH-1:0] comp_mem_q, comp_mem_d;

   logic        full_c, empty_c, fire_c, head_vld_c, bypass_c, push_c, pop_c;
   logic        rsp_comp_c;
   logic [31:0] rsp_inst_c;

   assign fetch_addr_o = pc_q;
   assign count_o      = count_q;

   // Fetch handshake and length decode of the returned halfword pair
   always_comb begin
      full_c        = (count_q == CW'(DEPTH));
      empty_c       = (count_q == '0);
      fetch_valid_o = rst_ni & ~full_c & ~redirect_i;
      fire_c        = fetch_valid_o & fetch_rsp_valid_i;
      rsp_comp_c    = (fetch_rsp_data_i[1:0] != 2'b11);
      rsp_inst_c    = rsp_comp_c ? {16'h0000, fetch_rsp_data_i[15:0]} : fetch_rsp_data_i;
      head_vld_c    = rst_ni & ~empty_c;
      bypass_c      = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass_c      = fire_c & empty_c;
`endif
   end

   // Head presentation; zero whenever nothing valid is offered
   always_comb begin
      inst_valid_o = head_vld_c | bypass_c;
      inst_o       = '0;
      inst_pc_o    = '0;
      inst_comp_o  = 1'b0;
      if (head_vld_c) begin
         inst_o      = inst_mem_q[rd_ptr_q];
         inst_pc_o   = pc_mem_q[rd_ptr_q];
         inst_comp_o = comp_mem_q[rd_ptr_q];
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (bypass_c) begin
         inst_o      = rsp_inst_c;
         inst_pc_o   = pc_q;
         inst_comp_o = rsp_comp_c;
      end
`endif
   end

   // Next-state: queue push/pop, PC advance, redirect flush last so it wins
   always_comb begin
      push_c     = fire_c & ~(bypass_c & inst_ready_i);
      pop_c      = head_vld_c & inst_ready_i;
      pc_d       = pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      comp_mem_d = comp_mem_q;
      if (push_c) begin
         pc_mem_d[wr_ptr_q]   = pc_q;
         inst_mem_d[wr_ptr_q] = rsp_inst_c;
         comp_mem_d[wr_ptr_q] = rsp_comp_c;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      if (fire_c) begin
         pc_d = pc_q + (rsp_comp_c ? XLEN'(2) : XLEN'(4));
      end
      if (redirect_i) begin
         pc_d     = {redirect_pc_i[XLEN-1:1], 1'b0};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q     <= RESET_VECTOR;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is only shown while count_q is nonzero
   always_ff @(posedge clk_i) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      comp_mem_q <= comp_mem_d;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model of the fetch/decode rules.
module tb_fetch_queue;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RV    = 32'h8000_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni, redirect_i, fetch_rsp_valid_i, inst_ready_i;
   logic [31:0] redirect_pc_i, fetch_rsp_data_i;
   logic        fetch_valid_o, inst_valid_o, inst_comp_o;
   logic [31:0] fetch_addr_o, inst_o, inst_pc_o;
   logic [2:0]  count_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        comp;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;

   always #5 clk_i = ~clk_i;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .fetch_valid_o(fetch_valid_o), .fetch_addr_o(fetch_addr_o),
      .fetch_rsp_valid_i(fetch_rsp_valid_i), .fetch_rsp_data_i(fetch_rsp_data_i),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
      .inst_pc_o(inst_pc_o), .inst_comp_o(inst_comp_o), .count_o(count_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle, compare against the model, then advance the model across the edge.
   task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc,
                        input logic rv, input logic [31:0] data, input logic rdy);
      logic efv, fire, byp, eiv, comp;
      ent_t head, rsp;
      @(negedge clk_i);
      rst_ni = rst; redirect_i = redir; redirect_pc_i = rpc;
      fetch_rsp_valid_i = rv; fetch_rsp_data_i = data; inst_ready_i = rdy;
      #1;
      comp      = (data[1:0] != 2'b11);
      rsp.pc    = mpc;
      rsp.inst  = comp ? {16'h0, data[15:0]} : data;
      rsp.comp  = comp;
      efv  = rst && (mq.size() < DEPTH) && !redir;
      fire = efv && rv;
      byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp  = fire && (mq.size() == 0);
`endif
      eiv  = rst && ((mq.size() > 0) || byp);
      head = (mq.size() > 0) ? mq[0] : rsp;
      check("fetch_valid", 64'(fetch_valid_o), 64'(efv));
      check("fetch_addr", 64'(fetch_addr_o), 64'(mpc));
      check("count", 64'(count_o), 64'(mq.size()));
      check("inst_valid", 64'(inst_valid_o), 64'(eiv));
      if (eiv) begin
         check("inst", 64'(inst_o), 64'(head.inst));
         check("inst_pc", 64'(inst_pc_o), 64'(head.pc));
         check("inst_comp", 64'(inst_comp_o), 64'(head.comp));
      end
      if (!rst) begin
         mq.delete();
         mpc = RV;
      end else if (redir) begin
         mq.delete();
         mpc = {rpc[31:1], 1'b0};
      end else begin
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (fire) begin
            if (!(byp && rdy)) mq.push_back(rsp);
            mpc = mpc + (comp ? 32'd2 : 32'd4);
         end
      end
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      logic [31:0] d;
      rst_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      fetch_rsp_valid_i = 1'b0; fetch_rsp_data_i = '0; inst_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      mpc = RV;
      cycle(1'b0, 1'b0, 0, 1'b1, 32'h13, 1'b1);
      check("rst_inst", 64'(inst_o), 64'd0);
      check("rst_inst_pc", 64'(inst_pc_o), 64'd0);
      check("rst_inst_comp", 64'(inst_comp_o), 64'd0);
      check("rst_count", 64'(count_o), 64'd0);

      // Fill from reset with 4-byte instructions, decode stalled
      repeat (5) cycle(1'b1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b0);
      check("fill_count", 64'(count_o), 64'd4);
      check("fill_head_pc", 64'(inst_pc_o), 64'(32'h8000_0000));
      check("fill_addr", 64'(fetch_addr_o), 64'(32'h8000_0010));
      // Full with decode ready: pop then refill
      cycle(1'b1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b1);
      check("full_pop_count", 64'(count_o), 64'd3);
      check("full_pop_head", 64'(inst_pc_o), 64'(32'h8000_0004));
      cycle(1'b1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b0);
      check("full_refill_count", 64'(count_o), 64'd4);

      // Redirect with a simultaneous response and pop, odd target
      cycle(1'b1, 1'b1, 32'h8000_0101, 1'b1, 32'hDEAD_BEEF, 1'b1);
      check("redir_count", 64'(count_o), 64'd0);
      check("redir_addr", 64'(fetch_addr_o), 64'(32'h8000_0100));
      check("redir_valid", 64'(inst_valid_o), 64'd0);

      // Mixed lengths
      cycle(1'b1, 1'b1, 32'h8000_0000, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b1, 32'hABCD_4501, 1'b0);
      check("mix_addr1", 64'(fetch_addr_o), 64'(32'h8000_0002));
      check("mix_inst", 64'(inst_o), 64'(32'h0000_4501));
      check("mix_comp", 64'(inst_comp_o), 64'd1);
      cycle(1'b1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b0);
      check("mix_addr2", 64'(fetch_addr_o), 64'(32'h8000_0006));

      // PC wrap-around
      cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b0);
      check("wrap_addr", 64'(fetch_addr_o), 64'(32'h0000_0002));
      check("wrap_head_pc", 64'(inst_pc_o), 64'(32'hFFFF_FFFE));

      // Empty queue, response with decode ready
      cycle(1'b1, 1'b1, 32'h8000_0000, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
      check("byp_count", 64'(count_o), 64'd0);
`else
      check("nobyp_valid_next", 64'(inst_valid_o), 64'd1);
      check("nobyp_count", 64'(count_o), 64'd1);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         d = $urandom;
         if ($urandom_range(1, 0) == 0) d[1:0] = 2'b11;
         cycle($urandom_range(99, 0) >= 2,
               $urandom_range(99, 0) < 5,
               ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h7)) : $urandom,
               $urandom_range(99, 0) < 65,
               d,
               $urandom_range(99, 0) < 50);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
